// File: rtl/noc_config_pkg.sv
// Shared NoC configuration structure and its default value.
package noc_config_pkg;

   typedef struct packed {
      int unsigned virtual_channels;
      int unsigned flit_width;
      int unsigned buffer_depth;
   } noc_config_t;

   localparam noc_config_t NOC_DEFAULT_CONFIG = '{
      virtual_channels: 2,
      flit_width:       32,
      buffer_depth:     4
   };

endpackage

// File: rtl/noc_round_robin_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above i_pointer,
// wrapping to the lowest request when none is found above it.
module noc_round_robin_arbiter #(
   parameter  int unsigned N    = 2,
   localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    i_request,
   input  logic [PtrW-1:0] i_pointer,
   output logic [N-1:0]    o_grant
);

   logic [N-1:0] w_hi;
   logic [N-1:0] w_lo;
   logic         w_hi_found;
   logic         w_lo_found;

   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (i_request[i] && !w_lo_found) begin
            w_lo[i]    = 1'b1;
            w_lo_found = 1'b1;
         end
         if (i_request[i] && (i >= int'(i_pointer)) && !w_hi_found) begin
            w_hi[i]    = 1'b1;
            w_hi_found = 1'b1;
         end
      end
      o_grant = w_hi_found ? w_hi : w_lo;
   end

endmodule

// File: rtl/noc_vc_arbiter.sv
// Per-output-port VC arbiter: round-robin head selection, grant locked until the tail transfers.
// Optional per-VC saturating flit counters enabled by NOC_VC_ARB_PERF_EN.
module noc_vc_arbiter
   import noc_config_pkg::*;
#(
   parameter  noc_config_t CONFIG   = NOC_DEFAULT_CONFIG,
   localparam int unsigned CHANNELS = CONFIG.virtual_channels,
   localparam int unsigned PtrW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
`ifdef NOC_VC_ARB_PERF_EN
   ,
   localparam int unsigned FlitCntW = 16
`endif
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [CHANNELS-1:0]               i_valid,
   input  logic [CHANNELS-1:0]               i_head,
   input  logic [CHANNELS-1:0]               i_tail,
   input  logic                              i_ready,
   output logic [CHANNELS-1:0]               o_vc_grant,
`ifdef NOC_VC_ARB_PERF_EN
   output logic [CHANNELS-1:0][FlitCntW-1:0] o_flit_count,
`endif
   output logic                              o_busy
);

   typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic [PtrW-1:0]     r_ptr;
   logic [PtrW-1:0]     w_ptr_nxt;
   logic [CHANNELS-1:0] r_lock;
   logic [CHANNELS-1:0] w_lock_nxt;
   logic [CHANNELS-1:0] w_req;
   logic [CHANNELS-1:0] w_winner;
   logic [CHANNELS-1:0] w_grant;
   logic                w_xfer;
   logic                w_tail;
   logic [PtrW-1:0]     w_grant_idx;
   logic [PtrW-1:0]     w_next_ptr;

   assign w_req = i_valid & i_head;

   noc_round_robin_arbiter #(
      .N (CHANNELS)
   ) u_rr_arb (
      .i_request (w_req),
      .i_pointer (r_ptr),
      .o_grant   (w_winner)
   );

   assign w_grant    = (r_state == StIdle) ? w_winner : r_lock;
   assign w_xfer     = (|(w_grant & i_valid)) & i_ready;
   assign w_tail     = |(w_grant & i_tail);
   assign o_vc_grant = w_grant;
   assign o_busy     = (r_state == StLocked);

   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (w_grant[i]) begin
            w_grant_idx = PtrW'(i);
         end
      end
   end

   // Covers CHANNELS=1 too: the only index is CHANNELS-1, so the pointer stays 0.
   assign w_next_ptr = (w_grant_idx == PtrW'(CHANNELS - 1)) ? '0 : w_grant_idx + PtrW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock;
      unique case (r_state)
         StIdle: begin
            if (w_xfer) begin
               if (w_tail) begin
                  w_ptr_nxt = w_next_ptr;
               end else begin
                  w_state_nxt = StLocked;
                  w_lock_nxt  = w_winner;
               end
            end
         end
         StLocked: begin
            if (w_xfer && w_tail) begin
               w_state_nxt = StIdle;
               w_lock_nxt  = '0;
               w_ptr_nxt   = w_next_ptr;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_lock  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_lock  <= w_lock_nxt;
      end
   end

`ifdef NOC_VC_ARB_PERF_EN
   logic [CHANNELS-1:0][FlitCntW-1:0] r_flit_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flit_count <= '0;
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (w_xfer && w_grant[i] && (r_flit_count[i] != '1)) begin
               r_flit_count[i] <= r_flit_count[i] + FlitCntW'(1);
            end
         end
      end
   end

   assign o_flit_count = r_flit_count;
`endif

endmodule
